fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch unit that consumes the branch resolution outputs (`branching`, target select) and turns them into PC redirection, instruction-memory requests and younger-stage flushes. It sits at the front of the pipeline. It owns the architectural fetch PC, keeps at most one instruction-memory request outstanding, discards responses made stale by a redirect, and holds a one-entry output register toward decode.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `branching_i`  in  1  redirect request from branch resolution.
- `target_sel_i`  in  2  redirect source: 00 ALU, 01 MTVEC, 10 MEPC, 11 treated as ALU.
- `alu_target_i`  in  32  branch/jump target.
- `mtvec_i`  in  32  trap vector.
- `mepc_i`  in  32  exception return address.
- `stall_i`  in  1  decode cannot accept `instr_o` this cycle.
- `imem_req_o`  out  1  fetch request.
- `imem_addr_o`  out  32  fetch address, word aligned.
- `imem_gnt_i`  in  1  request accepted this cycle.
- `imem_rvalid_i`  in  1  response data valid.
- `imem_rdata_i`  in  32  response instruction.
- `instr_valid_o`  out  1  output register holds an instruction.
- `instr_o`  out  32  fetched instruction.
- `instr_pc_o`  out  32  PC of `instr_o`.
- `flush_o`  out  1  kill younger pipeline stages.

## Operation
- Redirect target is the source selected by `target_sel_i`, with bits [1:0] forced to 0.
- `flush_o` = `branching_i` (combinational).
- States: IDLE, REQ, WAIT, KILL. Reset state is IDLE.
- IDLE: moves unconditionally to REQ on the first clock edge with `rst_i` low.
- REQ:
  - `imem_req_o` = 1 only when `!instr_valid_o || !stall_i`.
  - `imem_addr_o` = `pc`.
  - On `branching_i`, `pc` <= target.
  - If a grant coincides with `branching_i`, the granted request is stale: go to KILL.
  - On `imem_gnt_i` without `branching_i`: `req_pc` <= `pc`, `pc` <= `pc`+4, go to WAIT.
- WAIT:
  - On `imem_rvalid_i` without `branching_i`: load `{instr_o, instr_pc_o}` <= `{imem_rdata_i, req_pc}`, set `instr_valid_o`, go to REQ.
  - On `branching_i` with `imem_rvalid_i`: drop the data, `pc` <= target, go to REQ.
  - On `branching_i` without `imem_rvalid_i`: `pc` <= target, go to KILL.
- KILL:
  - Waits for the stale response and drops it on `imem_rvalid_i`, then goes to REQ.
  - `branching_i` in KILL updates `pc` only.
- Output register:
  - Cleared by `branching_i`; this has priority over a load.
  - Cleared when `instr_valid_o && !stall_i` and nothing is loaded that cycle.
  - Holds its contents while stalled.
- The issue rule (buffer empty or draining at grant time) guarantees a response never arrives while the output register is full. No overflow path exists.
- Address and PC arithmetic is 32-bit and wraps modulo 2^32 (0xFFFF_FFFC+4 = 0).

## Timing
- Reset values: `imem_req_o`=0, `imem_addr_o`=`RESET_PC`, `instr_valid_o`=0, `instr_o`=0, `instr_pc_o`=0, `flush_o`=`branching_i`, `pc`=`RESET_PC`.
- While `imem_req_o` is high without a grant:
  - `imem_addr_o` is stable, except that `branching_i` may change it.
  - An ungranted request may be retargeted or dropped (the stall condition).
- With a zero-wait memory (grant same cycle, rvalid next cycle), fetch latency is 2 cycles request-to-`instr_valid_o`. Throughput is one instruction per 2 cycles.
- Redirect-to-new-request: 1 cycle from REQ or WAIT. From KILL, the new request issues in the cycle after the stale response.
- `rst_i` asserted mid-transaction returns to IDLE immediately. The bench memory model must also be reset, because any in-flight response is not tracked.

## Structure
- Shared package `fetch_pkg`: target-select encodings (ALU_TARGET=00, MTVEC_TARGET=01, MEPC_TARGET=10). These encodings are also imported by branch resolution.
- Shared package `fetch_pkg` also holds the state enum, `XLEN`=32 and `INSTR_BYTES`=4.
- One natural sub-module: `fetch_target_mux` (select plus alignment). Everything else stays flat.

## Test plan
- **Reset and sequential fetch.** Release reset with a zero-wait memory returning 0x00000013 -> requests at 0x0, 0x4, 0x8. `instr_valid_o` first high 2 cycles after the first request, with `instr_pc_o`=0x0.
- **Stall.** Hold `stall_i` for 5 cycles with the output register full -> `instr_o` and `instr_pc_o` unchanged, no new grant taken. The fetch resumes the cycle after the stall releases.
- **Redirect in WAIT.** Raise `branching_i`, sel=00, `alu_target_i`=0x100 one cycle before rvalid -> state KILL, the stale response is dropped, the next request is at 0x100, `instr_valid_o` is cleared.
- **Grant coincident with redirect.** `imem_gnt_i` and `branching_i` in the same cycle (sel=01, `mtvec_i`=0x200) -> KILL, then a request at 0x200.
- **Target select and alignment.** sel=10 with `mepc_i`=0x303 -> fetch at 0x300. sel=11 with `alu_target_i`=0x40 -> fetch at 0x40.
- **Wrap and mid-fetch reset.** Start at `pc`=0xFFFF_FFFC -> the next request is at 0x0. Assert `rst_i` in WAIT -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch definitions: word size, redirect-source encodings, fetch FSM states.
// Branch resolution also imports the target-select encodings.
package fetch_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      ALU_TARGET   = 2'b00,
      MTVEC_TARGET = 2'b01,
      MEPC_TARGET  = 2'b10
   } target_sel_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10,
      KILL = 2'b11
   } fetch_state_t;

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_target_mux.sv
// Redirect target selection; the chosen source is forced to a word boundary.
module fetch_target_mux
   import fetch_pkg::*;
(
   input  logic [1:0]      sel,
   input  logic [XLEN-1:0] alu_target,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] mepc,
   output logic [XLEN-1:0] target
);

   logic [XLEN-1:0] raw;

   always_comb begin
      raw = alu_target;
      case (sel)
         MTVEC_TARGET: raw = mtvec;
         MEPC_TARGET:  raw = mepc;
         default:      raw = alu_target;
      endcase
      target = align_word(raw);
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, keeps one imem request in flight,
// drops responses made stale by a redirect and buffers one instruction for decode.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            branching_i,
   input  logic [1:0]      target_sel_i,
   input  logic [XLEN-1:0] alu_target_i,
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] mepc_i,
   input  logic            stall_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            instr_valid_o,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   output logic            flush_o
);

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] req_pc;
   logic [XLEN-1:0] target;
   logic            issue;
   logic            granted;
   logic            load;

   fetch_target_mux u_target_mux (
      .sel        (target_sel_i),
      .alu_target (alu_target_i),
      .mtvec      (mtvec_i),
      .mepc       (mepc_i),
      .target     (target)
   );

   // Only issue when the output register is empty or drains this cycle,
   // so a response can never find the register full.
   assign issue   = (state == REQ) && (!instr_valid_o || !stall_i);
   assign granted = issue && imem_gnt_i;
   assign load    = (state == WAIT) && imem_rvalid_i && !branching_i;

   assign imem_req_o  = issue;
   assign imem_addr_o = pc;
   assign flush_o     = branching_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= IDLE;
         pc            <= RESET_PC;
         req_pc        <= '0;
         instr_valid_o <= 1'b0;
         instr_o       <= '0;
         instr_pc_o    <= '0;
      end else begin
         if (branching_i) begin
            instr_valid_o <= 1'b0;
         end else if (load) begin
            instr_valid_o <= 1'b1;
            instr_o       <= imem_rdata_i;
            instr_pc_o    <= req_pc;
         end else if (instr_valid_o && !stall_i) begin
            instr_valid_o <= 1'b0;
         end

         case (state)
            IDLE: state <= REQ;
            REQ: begin
               if (branching_i) begin
                  pc <= target;
                  if (granted) state <= KILL;
               end else if (granted) begin
                  req_pc <= pc;
                  pc     <= pc + XLEN'(INSTR_BYTES);
                  state  <= WAIT;
               end
            end
            WAIT: begin
               if (branching_i) begin
                  pc    <= target;
                  state <= imem_rvalid_i ? REQ : KILL;
               end else if (imem_rvalid_i) begin
                  state <= REQ;
               end
            end
            KILL: begin
               if (branching_i) pc <= target;
               if (imem_rvalid_i) state <= REQ;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a configurable-latency instruction memory.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        branching_i;
   logic [1:0]  target_sel_i;
   logic [31:0] alu_target_i;
   logic [31:0] mtvec_i;
   logic [31:0] mepc_i;
   logic        stall_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        flush_o;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .branching_i   (branching_i),
      .target_sel_i  (target_sel_i),
      .alu_target_i  (alu_target_i),
      .mtvec_i       (mtvec_i),
      .mepc_i        (mepc_i),
      .stall_i       (stall_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .flush_o       (flush_o)
   );

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int          cyc   = 0;
   int          first_req;
   int          first_val;
   exp_t        sb[$];
   logic [31:0] gaddr[$];
   logic        record_gnt = 1'b0;
   logic [31:0] exp_pc;

   logic        mem_pend;
   int unsigned mem_wait;
   int unsigned mem_lat = 1;
   logic [31:0] mem_data;

   logic        saw_req;
   logic        saw_gnt;
   logic [31:0] saw_addr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[23:0], 8'h13};
   endfunction

   function automatic logic [31:0] model_target(input logic [1:0] s, input logic [31:0] a,
                                                input logic [31:0] t, input logic [31:0] e);
      logic [31:0] r;
      case (s)
         2'b01:   r = t;
         2'b10:   r = e;
         default: r = a;
      endcase
      return r & 32'hFFFF_FFFC;
   endfunction

   // One clock: drive at negedge, memory answers, sample and update the model before posedge.
   task automatic cycle(input logic br, input logic stall);
      exp_t e;
      @(negedge clk);
      branching_i = br;
      stall_i     = stall;
      #1;
      imem_gnt_i    = imem_req_o;
      imem_rvalid_i = mem_pend && (mem_wait == 0);
      imem_rdata_i  = imem_rvalid_i ? mem_data : 32'hDEAD_BEEF;
      #1;
      check("flush", flush_o, br);
      saw_req  = imem_req_o;
      saw_gnt  = imem_gnt_i;
      saw_addr = imem_addr_o;
      if (imem_req_o) check("req_addr", imem_addr_o, exp_pc);
      if (imem_req_o && first_req < 0) first_req = cyc;
      if (instr_valid_o && first_val < 0) first_val = cyc;
      if (instr_valid_o && !stall && !br) begin
         check("deliver_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("instr", instr_o, e.instr);
            check("instr_pc", instr_pc_o, e.pc);
         end
      end
      if (imem_rvalid_i) mem_pend = 1'b0;
      else if (mem_pend) mem_wait--;
      if (imem_gnt_i) begin
         mem_pend = 1'b1;
         mem_wait = mem_lat - 1;
         mem_data = mem_word(imem_addr_o);
         sb.push_back({mem_word(exp_pc), exp_pc});
         if (record_gnt) gaddr.push_back(imem_addr_o);
      end
      if (br) begin
         sb.delete();
         exp_pc = model_target(target_sel_i, alu_target_i, mtvec_i, mepc_i);
      end else if (imem_gnt_i) begin
         exp_pc = exp_pc + 32'd4;
      end
      @(posedge clk);
      #1;
      cyc++;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
   endtask

   task automatic wait_gnt(input string tag);
      int unsigned n = 0;
      do begin cycle(1'b0, 1'b0); n++; end while (!saw_gnt && n < 20);
      check(tag, saw_gnt, 1'b1);
   endtask

   task automatic wait_req(input string tag);
      int unsigned n = 0;
      do begin cycle(1'b0, 1'b0); n++; end while (!saw_req && n < 20);
      check(tag, saw_req, 1'b1);
   endtask

   task automatic hold_reset();
      rst_i         = 1'b1;
      branching_i   = 1'b0;
      stall_i       = 1'b0;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      mem_pend      = 1'b0;
      mem_wait      = 0;
      sb.delete();
      exp_pc        = RST_PC;
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; branching_i = 1'b0; target_sel_i = 2'b00; stall_i = 1'b0;
      alu_target_i = '0; mtvec_i = '0; mepc_i = '0;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      mem_pend = 1'b0; mem_wait = 0; mem_data = '0; exp_pc = RST_PC;
      first_req = -1; first_val = -1;

      // Reset values
      #12;
      check("rst_req", imem_req_o, 1'b0);
      check("rst_addr", imem_addr_o, RST_PC);
      check("rst_valid", instr_valid_o, 1'b0);
      check("rst_instr", instr_o, 32'h0);
      check("rst_instr_pc", instr_pc_o, 32'h0);
      branching_i = 1'b1; #1;
      check("rst_flush_hi", flush_o, 1'b1);
      branching_i = 1'b0; #1;
      check("rst_flush_lo", flush_o, 1'b0);
      hold_reset();

      // Sequential fetch with zero-wait memory
      first_req = -1; first_val = -1; record_gnt = 1'b1;
      repeat (8) cycle(1'b0, 1'b0);
      record_gnt = 1'b0;
      check("latency", 32'(first_val - first_req), 32'd2);
      check("gnt_count", gaddr.size(), 32'd4);
      if (gaddr.size() >= 3) begin
         check("seq_addr0", gaddr[0], 32'h0);
         check("seq_addr1", gaddr[1], 32'h4);
         check("seq_addr2", gaddr[2], 32'h8);
      end

      // Stall with output register full
      begin
         int unsigned n = 0;
         while (!instr_valid_o && n < 20) begin cycle(1'b0, 1'b1); n++; end
         check("stall_fill", instr_valid_o, 1'b1);
         check("stall_sb", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
         for (int unsigned i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1);
            check("stall_noreq", saw_req, 1'b0);
            check("stall_valid", instr_valid_o, 1'b1);
            if (sb.size() > 0) begin
               check("stall_instr", instr_o, sb[0].instr);
               check("stall_pc", instr_pc_o, sb[0].pc);
            end
         end
         cycle(1'b0, 1'b0);
         check("stall_resume", saw_req, 1'b1);
      end

      // Redirect in WAIT one cycle before rvalid
      mem_lat = 2;
      wait_gnt("wait_redir_gnt");
      target_sel_i = 2'b00; alu_target_i = 32'h100;
      cycle(1'b1, 1'b0);
      check("wait_redir_noreq", saw_req, 1'b0);
      cycle(1'b0, 1'b0);
      check("kill_noreq", saw_req, 1'b0);
      check("kill_valid", instr_valid_o, 1'b0);
      cycle(1'b0, 1'b0);
      check("redir_req", saw_req, 1'b1);
      check("redir_addr", saw_addr, 32'h100);
      mem_lat = 1;

      // Grant coincident with redirect
      begin
         int unsigned n = 0;
         while (!imem_req_o && n < 20) begin cycle(1'b0, 1'b0); n++; end
         check("coinc_ready", imem_req_o, 1'b1);
      end
      target_sel_i = 2'b01; mtvec_i = 32'h200;
      cycle(1'b1, 1'b0);
      check("coinc_gnt", saw_gnt, 1'b1);
      cycle(1'b0, 1'b0);
      check("coinc_kill_noreq", saw_req, 1'b0);
      cycle(1'b0, 1'b0);
      check("coinc_req", saw_req, 1'b1);
      check("coinc_addr", saw_addr, 32'h200);

      // Target select and alignment
      target_sel_i = 2'b10; mepc_i = 32'h303;
      cycle(1'b1, 1'b0);
      wait_req("mepc_req");
      check("mepc_addr", saw_addr, 32'h300);
      target_sel_i = 2'b11; alu_target_i = 32'h40;
      cycle(1'b1, 1'b0);
      wait_req("sel11_req");
      check("sel11_addr", saw_addr, 32'h40);

      // Wrap at the top of the address space
      target_sel_i = 2'b00; alu_target_i = 32'hFFFF_FFFC;
      cycle(1'b1, 1'b0);
      wait_req("wrap_req0");
      check("wrap_addr0", saw_addr, 32'hFFFF_FFFC);
      wait_req("wrap_req1");
      check("wrap_addr1", saw_addr, 32'h0);
      repeat (3) cycle(1'b0, 1'b0);

      // Asynchronous reset while waiting for a response
      mem_lat = 3;
      wait_gnt("mid_gnt");
      #2;
      rst_i = 1'b1;
      #1;
      check("mid_rst_req", imem_req_o, 1'b0);
      check("mid_rst_addr", imem_addr_o, RST_PC);
      check("mid_rst_valid", instr_valid_o, 1'b0);
      check("mid_rst_instr", instr_o, 32'h0);
      check("mid_rst_instr_pc", instr_pc_o, 32'h0);
      mem_lat = 1;
      hold_reset();
      wait_req("post_rst_req");
      check("post_rst_addr", saw_addr, RST_PC);
      repeat (6) cycle(1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
